// File: rtl/reg_arb.sv
// Two-requester round-robin arbiter in front of a single-cycle register bus.
// Each access takes three cycles: IDLE (arbitrate) -> ACCESS (strobe) -> DONE (ack).
module reg_arb #(
   parameter logic [5:0] MAX_ADDR = 6'h1F
) (
   input  logic       clk,
   input  logic       rst,

   input  logic       m0_req,
   input  logic       m0_we,
   input  logic [5:0] m0_addr,
   input  logic [7:0] m0_wdata,
   output logic       m0_ack,
   output logic       m0_err,
   output logic [7:0] m0_rdata,

   input  logic       m1_req,
   input  logic       m1_we,
   input  logic [5:0] m1_addr,
   input  logic [7:0] m1_wdata,
   output logic       m1_ack,
   output logic       m1_err,
   output logic [7:0] m1_rdata,

   output logic       read,
   output logic       write,
   output logic [5:0] addr,
   output logic [7:0] data_write,
   input  logic [7:0] data_read
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t     state;
   logic       last_grant;
   logic       gnt;
   logic       lat_we;
   logic       lat_legal;
   logic [7:0] m0_hold;
   logic [7:0] m1_hold;

   logic       sel_m1;
   logic       sel_we;
   logic       sel_legal;
   logic [5:0] sel_addr;
   logic [7:0] sel_wdata;

   // m1 wins when it is the only requester, or on a conflict when m0 had the last grant.
   always_comb begin
      sel_m1    = m1_req & (~m0_req | ~last_grant);
      sel_we    = sel_m1 ? m1_we    : m0_we;
      sel_addr  = sel_m1 ? m1_addr  : m0_addr;
      sel_wdata = sel_m1 ? m1_wdata : m0_wdata;
      sel_legal = (sel_addr <= MAX_ADDR);
   end

   // Read data only arrives during DONE, so it is forwarded straight through in
   // that cycle and captured into the hold register at the end of it.
   always_comb begin
      m0_rdata = m0_hold;
      m1_rdata = m1_hold;
      if (state == DONE && !lat_we) begin
         if (gnt) begin
            m1_rdata = lat_legal ? data_read : '0;
         end else begin
            m0_rdata = lat_legal ? data_read : '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         gnt        <= 1'b0;
         lat_we     <= 1'b0;
         lat_legal  <= 1'b0;
         read       <= 1'b0;
         write      <= 1'b0;
         addr       <= '0;
         data_write <= '0;
         m0_ack     <= 1'b0;
         m1_ack     <= 1'b0;
         m0_err     <= 1'b0;
         m1_err     <= 1'b0;
         m0_hold    <= '0;
         m1_hold    <= '0;
      end else begin
         read       <= 1'b0;
         write      <= 1'b0;
         addr       <= '0;
         data_write <= '0;
         m0_ack     <= 1'b0;
         m1_ack     <= 1'b0;
         m0_err     <= 1'b0;
         m1_err     <= 1'b0;
         unique case (state)
            IDLE: begin
               if (m0_req || m1_req) begin
                  state      <= ACCESS;
                  gnt        <= sel_m1;
                  last_grant <= sel_m1;
                  lat_we     <= sel_we;
                  lat_legal  <= sel_legal;
                  // The strobe registers double as the latched command for ACCESS.
                  if (sel_legal) begin
                     write      <= sel_we;
                     read       <= ~sel_we;
                     addr       <= sel_addr;
                     data_write <= sel_we ? sel_wdata : '0;
                  end
               end
            end
            ACCESS: begin
               state <= DONE;
               if (gnt) begin
                  m1_ack <= 1'b1;
                  m1_err <= ~lat_legal;
               end else begin
                  m0_ack <= 1'b1;
                  m0_err <= ~lat_legal;
               end
            end
            DONE: begin
               state <= IDLE;
               if (!lat_we) begin
                  if (gnt) begin
                     m1_hold <= lat_legal ? data_read : '0;
                  end else begin
                     m0_hold <= lat_legal ? data_read : '0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/reg_arb.md
REG_ARB -- requirements
Module: reg_arb

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter: MAX_ADDR, 6'h1F, highest register address that is legal on the register bus.
REQ-003 Port: clk  input  1  peripheral clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Ports (requester 0, SPI instruction decoder side):
- m0_req  input  1  access request (level)
- m0_we  input  1  1 = write, 0 = read
- m0_addr  input  6  register address
- m0_wdata  input  8  write data
- m0_ack  output  1  one-cycle completion pulse
- m0_err  output  1  one-cycle pulse with m0_ack for an illegal address
- m0_rdata  output  8  read data
REQ-006 Ports m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata SHALL be identical for requester 1 (internal status/counter updater).
REQ-007 Register-bus ports:
- read  output  1  read strobe
- write  output  1  write strobe
- addr  output  6  register address
- data_write  output  8  write data
- data_read  input  8  read data, valid the cycle after read is high

Function
REQ-008 FSM states: IDLE, ACCESS, DONE; reset state IDLE.
REQ-009 IDLE: no mX_req sampled high -> stay IDLE; otherwise grant a requester, latch its we/addr/wdata and the grant index, go to ACCESS.
REQ-010 Round-robin grant:
- Register last_grant, reset value 1, so m0 wins the first conflict.
- Both requests high -> grant the index != last_grant.
- One request high -> grant it.
- last_grant SHALL update on every grant.
REQ-011 ACCESS lasts exactly one cycle:
- Legal address (latched addr <= MAX_ADDR): assert write (we=1) or read (we=0) for that cycle, with addr = latched address and data_write = latched wdata (0x00 for reads).
- Always go to DONE.
REQ-012 ACCESS with latched addr > MAX_ADDR SHALL assert neither read nor write.
REQ-013 DONE lasts exactly one cycle, then go to IDLE:
- Pulse the granted requester's mX_ack.
- Legal read: that requester's mX_rdata <= data_read.
- Illegal address: pulse mX_err together with mX_ack and load mX_rdata <= 0x00 if the access was a read.
REQ-014 Latency: req sampled at edge N -> strobe during cycle N+1 -> ack and rdata valid during cycle N+2. Maximum throughput is one access per 3 cycles.
REQ-015 read and write SHALL never be high together, and each SHALL be high for at most one cycle per transaction.
REQ-016 When read and write are both low, addr and data_write SHALL be 0.
REQ-017 mX_rdata SHALL hold its value between that requester's read completions; write acks and the other requester's acks SHALL leave it unchanged.
REQ-018 Changes on mX_we/addr/wdata after the grant SHALL be ignored until the next grant.
REQ-019 A requester dropping req after the grant SHALL still receive its ack, and the access SHALL still be performed.
REQ-020 A requester still holding req in the IDLE cycle after its ack SHALL be treated as a new request under REQ-010, so back-to-back accesses are allowed.
REQ-021 The ungranted requester's ack and err SHALL stay 0, and its request SHALL wait without loss.

Reset
REQ-022 rst high at a clock edge SHALL force state IDLE and last_grant=1, and SHALL clear read, write, addr, data_write, m0_ack, m1_ack, m0_err, m1_err, m0_rdata and m1_rdata to 0.
REQ-023 Reset in ACCESS or DONE SHALL abort the transaction with no ack and no further strobe; after reset release, a held req SHALL be re-arbitrated.

Verification
REQ-024 Single write: m0 req, we=1, addr=0x05, wdata=0xA5 -> write=1, addr=0x05, data_write=0xA5 in cycle N+1; m0_ack=1 in cycle N+2; m0_err=0.
REQ-025 Single read: m1 read of addr 0x02 with data_read=0x3C during cycle N+2 -> read=1 in cycle N+1; m1_ack=1 and m1_rdata=0x3C in cycle N+2; m0_rdata unchanged.
REQ-026 Contention: m0 and m1 both held after reset -> grants alternate m0, m1, m0, m1; each ack 3 cycles apart; no cycle with both acks high.
REQ-027 Illegal address: m0 read of addr 0x20 with MAX_ADDR=0x1F -> no read/write strobe; m0_ack=1, m0_err=1 and m0_rdata=0x00 in cycle N+2.
REQ-028 Mid-operation: m0 write granted, rst=1 during ACCESS -> all outputs 0 next cycle and no m0_ack; m0_req still high after release -> write re-issued 1 cycle after the first sampled edge.
REQ-029 Command hold: m1 addr changed from 0x01 to 0x07 and req dropped the cycle after grant -> strobe still uses addr 0x01 and m1_ack still pulses.
